// File: rtl/pll_reset_sequencer.sv
// PLL reset initiator and lock supervisor: pulses the PLL reset, qualifies lock, releases system reset.
// Optional status outputs (state_o, retry_cnt, lock_loss_cnt) are built only with PLL_RST_SEQ_STATUS_EN.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 500000,
    parameter int STABLE_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       soft_rst_req,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic [1:0] state_o,
    output logic [7:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    // state     | meaning
    // PLL_RST   | PLL held in reset for PLL_RST_CYCLES
    // WAIT_LOCK | PLL running, waiting for lock or timeout
    // STABLE    | lock seen, qualifying for STABLE_CYCLES
    // RUN       | lock qualified, system reset released
    localparam logic [1:0] S_PLL_RST   = 2'd0;
    localparam logic [1:0] S_WAIT_LOCK = 2'd1;
    localparam logic [1:0] S_STABLE    = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_ALL = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int TW      = $clog2(MAX_ALL) + 1;

    localparam logic [TW-1:0] PLL_RST_TC = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_TC    = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_TC  = TW'(STABLE_CYCLES - 1);

    logic          locked_meta;
    logic          locked_s;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          retry_inc;
    logic          loss_inc;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer + 1'b1;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        if (soft_rst_req) begin
            state_nxt = S_PLL_RST;
            timer_nxt = '0;
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (timer == PLL_RST_TC) begin
                        state_nxt = S_WAIT_LOCK;
                        timer_nxt = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    // lock wins over a coincident timeout
                    if (locked_s) begin
                        state_nxt = S_STABLE;
                        timer_nxt = '0;
                    end else if (timer == LOCK_TC) begin
                        state_nxt = S_PLL_RST;
                        timer_nxt = '0;
                        retry_inc = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_nxt = S_WAIT_LOCK;
                        timer_nxt = '0;
                    end else if (timer == STABLE_TC) begin
                        state_nxt = S_RUN;
                        timer_nxt = '0;
                    end
                end
                S_RUN: begin
                    timer_nxt = '0;
                    if (!locked_s) begin
                        state_nxt = S_WAIT_LOCK;
                        loss_inc  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_PLL_RST;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // outputs are registered from next-state so they change on the transition edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
            state       <= S_PLL_RST;
            timer       <= '0;
            pll_rst     <= 1'b1;
            sys_reset   <= 1'b1;
        end else begin
            locked_meta <= locked;
            locked_s    <= locked_meta;
            state       <= state_nxt;
            timer       <= timer_nxt;
            pll_rst     <= (state_nxt == S_PLL_RST);
            sys_reset   <= (state_nxt != S_RUN);
        end
    end

`ifdef PLL_RST_SEQ_STATUS_EN
    logic [7:0] retry_q;
    logic [7:0] loss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_q <= 8'd0;
            loss_q  <= 8'd0;
        end else begin
            if (retry_inc && (retry_q != 8'hFF)) retry_q <= retry_q + 8'd1;
            if (loss_inc && (loss_q != 8'hFF))   loss_q  <= loss_q + 8'd1;
        end
    end

    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;
    assign state_o       = state;
`else
    logic status_unused;
    assign status_unused = retry_inc | loss_inc;
    assign retry_cnt     = 8'd0;
    assign lock_loss_cnt = 8'd0;
    assign state_o       = 2'd0;
`endif

endmodule
